cam_pix_loader: RTL and testbench

- Downstream stage of the camera capture FIFO, in the AI-core clock domain (r_clk).
- Requests one frame by holding rd_ready high, then accepts the stream of packed 16-bit RGB565 words (data_valid/data_in) that the capture stage pops from its FIFO.
- Unpacks each word to three 8-bit channels and writes them linearly into the AI input buffer through a single write port.
- Signals frame completion, and enforces a minimum rd_ready low time so the capture stage, which synchronises rd_ready into PCLK, sees the frame boundary.

---
 rtl/cam_pix_loader_pkg.sv | 26 ++
 rtl/cam_pix_loader_rgb565_unpack.sv | 32 +++
 rtl/cam_pix_loader.sv | 122 ++++++++++++
 tb/tb_cam_pix_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pix_loader_pkg.sv
// Shared camera definitions: FSM encoding, RGB565 field positions, frame geometry defaults.
// Pure declarations plus the channel output helper; no logic of its own.
package cam_pix_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd3
    } state_t;

    localparam int DEF_H_WIDTH = 112;
    localparam int DEF_V_WIDTH = 112;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // Flipping the MSB of an 8-bit unsigned channel yields x-128 in two's complement.
    function automatic logic [7:0] chan_out(input logic [7:0] c, input bit signed_out);
        return signed_out ? {~c[7], c[6:0]} : c;
    endfunction

endpackage

// File: rtl/cam_pix_loader_rgb565_unpack.sv
// RGB565 word (camera byte order) to {R8,G8,B8}, optionally zero-centred.
// Latency: combinational; no flow control.
module rgb565_unpack
    import cam_pix_loader_pkg::*;
#(
    parameter bit SIGNED_OUT = 1'b1
) (
    input  logic [15:0] word,
    output logic [23:0] rgb
);

    logic [15:0] pix;
    logic [4:0]  r5;
    logic [5:0]  g6;
    logic [4:0]  b5;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;

    always_comb begin
        pix = {word[7:0], word[15:8]};
        r5  = pix[R_MSB:R_LSB];
        g6  = pix[G_MSB:G_LSB];
        b5  = pix[B_MSB:B_LSB];
        // MSB replication spreads the narrow range across the full 0..255 scale.
        r8  = {r5, r5[4:2]};
        g8  = {g6, g6[5:4]};
        b8  = {b5, b5[4:2]};
        rgb = {chan_out(r8, SIGNED_OUT), chan_out(g8, SIGNED_OUT), chan_out(b8, SIGNED_OUT)};
    end

endmodule

// File: rtl/cam_pix_loader.sv
// Pulls one frame of RGB565 words from the capture FIFO and writes unpacked pixels to the AI buffer.
// Latency: one register stage to the write port; backpressure: none, words outside RECV are dropped.
module cam_pix_loader
    import cam_pix_loader_pkg::*;
#(
    parameter int H_WIDTH    = DEF_H_WIDTH,
    parameter int V_WIDTH    = DEF_V_WIDTH,
    parameter int ADDR_W     = 14,
    parameter bit SIGNED_OUT = 1'b1,
    parameter int MIN_LOW    = 8
) (
    input  logic              r_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              data_valid,
    input  logic [15:0]       data_in,
    output logic              rd_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              drop_err
);

    localparam int                NPIX     = H_WIDTH * V_WIDTH;
    localparam int                LW       = $clog2(MIN_LOW + 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
    localparam logic [LW-1:0]     LOW_SAT  = LW'(MIN_LOW);
    localparam logic [LW-1:0]     LOW_GO   = LW'(MIN_LOW - 1);

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [LW-1:0]     low_cnt_q, low_cnt_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic              drop_q, drop_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [23:0]       wdata_q, wdata_d;

    logic              pix_vld;
    logic              start_ok;
    logic              low_ok;
    logic [23:0]       rgb_dat;

    rgb565_unpack #(.SIGNED_OUT(SIGNED_OUT)) u_unpack (
        .word (data_in),
        .rgb  (rgb_dat)
    );

    always_ff @(posedge r_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            low_cnt_q <= LOW_SAT;
            pix_cnt_q <= '0;
            drop_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            low_cnt_q <= low_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            drop_q    <= drop_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        pix_vld  = (state_q == RECV) && data_valid && !abort;
        start_ok = (state_q == IDLE) && start && !abort;
        // Counter holds completed low cycles; one more low cycle (this one) meets MIN_LOW.
        low_ok   = (low_cnt_q >= LOW_GO);

        state_d = state_q;
        case (state_q)
            IDLE: if (low_ok && (start_ok || pend_q)) state_d = RECV;
            RECV: begin
                if (abort)                                state_d = IDLE;
                else if (pix_vld && pix_cnt_q == LAST_PIX) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        pend_d = 1'b0;
        if (state_q == IDLE && state_d == IDLE) pend_d = pend_q || start_ok;

        low_cnt_d = low_cnt_q;
        if (state_q == RECV) begin
            if (state_d != RECV) low_cnt_d = '0;
        end else if (low_cnt_q < LOW_SAT) begin
            low_cnt_d = low_cnt_q + LW'(1);
        end

        pix_cnt_d = pix_cnt_q;
        if (state_q != RECV && state_d == RECV) pix_cnt_d = '0;
        else if (pix_vld)                       pix_cnt_d = pix_cnt_q + ADDR_W'(1);

        drop_d = start_ok ? 1'b0 : drop_q;
        if (data_valid && (state_q == IDLE || state_q == DONE)) drop_d = 1'b1;
    end

    always_comb begin
        we_d       = pix_vld;
        addr_d     = pix_vld ? pix_cnt_q : addr_q;
        wdata_d    = pix_vld ? rgb_dat : wdata_q;
        rd_ready   = (state_q == RECV);
        busy       = (state_q != IDLE);
        frame_done = (state_q == DONE);
        mem_we     = we_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        drop_err   = drop_q;
    end

endmodule

// File: tb/tb_cam_pix_loader.sv
// Bench for cam_pix_loader on a 4x2 frame, with signed and unsigned instances sharing all inputs.
module tb_cam_pix_loader;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int NPIX = H * V;
    localparam int AW   = 14;
    localparam int ML   = 8;

    logic          r_clk = 1'b0;
    logic          rst, start, abort, data_valid;
    logic [15:0]   data_in;
    logic          rd_ready_s, mem_we_s, busy_s, frame_done_s, drop_err_s;
    logic [AW-1:0] mem_addr_s;
    logic [23:0]   mem_wdata_s;
    logic          rd_ready_u, mem_we_u, busy_u, frame_done_u, drop_err_u;
    logic [AW-1:0] mem_addr_u;
    logic [23:0]   mem_wdata_u;

    int checks = 0;
    int errors = 0;

    always #5 r_clk = ~r_clk;

    cam_pix_loader #(.H_WIDTH(H), .V_WIDTH(V), .ADDR_W(AW), .SIGNED_OUT(1'b1), .MIN_LOW(ML)) dut_s (
        .r_clk(r_clk), .rst(rst), .start(start), .abort(abort), .data_valid(data_valid),
        .data_in(data_in), .rd_ready(rd_ready_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
        .mem_wdata(mem_wdata_s), .busy(busy_s), .frame_done(frame_done_s), .drop_err(drop_err_s)
    );

    cam_pix_loader #(.H_WIDTH(H), .V_WIDTH(V), .ADDR_W(AW), .SIGNED_OUT(1'b0), .MIN_LOW(ML)) dut_u (
        .r_clk(r_clk), .rst(rst), .start(start), .abort(abort), .data_valid(data_valid),
        .data_in(data_in), .rd_ready(rd_ready_u), .mem_we(mem_we_u), .mem_addr(mem_addr_u),
        .mem_wdata(mem_wdata_u), .busy(busy_u), .frame_done(frame_done_u), .drop_err(drop_err_u)
    );

    typedef struct {
        logic [15:0] din;
        logic [23:0] exp_s;
        logic [23:0] exp_u;
    } vec_t;

    vec_t vecs [8];

    // Reference unpack from the numeric definition of each field.
    function automatic logic [23:0] model_rgb(input logic [15:0] w, input bit signed_out);
        int pix, r5, g6, b5, r8, g8, b8;
        pix = int'(w[7:0]) * 256 + int'(w[15:8]);
        r5  = pix / 2048;
        g6  = (pix / 32) % 64;
        b5  = pix % 32;
        r8  = r5 * 8 + r5 / 4;
        g8  = g6 * 4 + g6 / 16;
        b8  = b5 * 8 + b5 / 4;
        if (signed_out) begin
            r8 = (r8 + 256 - 128) % 256;
            g8 = (g8 + 256 - 128) % 256;
            b8 = (b8 + 256 - 128) % 256;
        end
        return {r8[7:0], g8[7:0], b8[7:0]};
    endfunction

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " rd_ready"},   32'(rd_ready_s),   0);
        chk({nm, " mem_we"},     32'(mem_we_s),     0);
        chk({nm, " mem_addr"},   32'(mem_addr_s),   0);
        chk({nm, " mem_wdata"},  32'(mem_wdata_s),  0);
        chk({nm, " busy"},       32'(busy_s),       0);
        chk({nm, " frame_done"}, 32'(frame_done_s), 0);
        chk({nm, " drop_err"},   32'(drop_err_s),   0);
        chk({nm, " u outputs"},  32'({rd_ready_u, mem_we_u, busy_u, frame_done_u, drop_err_u}), 0);
        chk({nm, " u addr"},     32'(mem_addr_u),   0);
        chk({nm, " u wdata"},    32'(mem_wdata_u),  0);
    endtask

    task automatic open_frame();
        int n;
        n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!rd_ready_s && n < 40) begin
            tick();
            n++;
        end
        chk("frame open rd_ready", 32'(rd_ready_s), 1);
    endtask

    task automatic put_word(input int idx, input bit is_last);
        logic [15:0] w;
        w = 16'($urandom);
        data_in    = w;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        chk("word mem_we",     32'(mem_we_s), 1);
        chk("word mem_addr",   32'(mem_addr_s), 32'(idx));
        chk("word wdata_s",    32'(mem_wdata_s), 32'(model_rgb(w, 1'b1)));
        chk("word wdata_u",    32'(mem_wdata_u), 32'(model_rgb(w, 1'b0)));
        chk("word frame_done", 32'(frame_done_s), 32'(is_last));
        chk("word rd_ready",   32'(rd_ready_s), 32'(!is_last));
    endtask

    task automatic feed_frame(input int gap, input bit extra_drop);
        int done_cnt;
        done_cnt = 0;
        for (int i = 0; i < NPIX; i++) begin
            put_word(i, i == NPIX - 1);
            done_cnt += int'(frame_done_s);
            if (i < NPIX - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("gap mem_we", 32'(mem_we_s), 0);
                    done_cnt += int'(frame_done_s);
                end
            end
        end
        if (extra_drop) begin
            data_valid = 1'b1;
            data_in    = 16'($urandom);
        end
        tick();
        data_valid = 1'b0;
        chk("post frame mem_we", 32'(mem_we_s), 0);
        done_cnt += int'(frame_done_s);
        chk("single frame_done", 32'(done_cnt), 1);
        if (extra_drop) chk("drop in DONE", 32'(drop_err_s), 1);
    endtask

    initial begin
        int low_cycles, n, seen;

        vecs[0] = '{16'h00F8, 24'h7F8080, 24'hFF0000};
        vecs[1] = '{16'hFFFF, 24'h7F7F7F, 24'hFFFFFF};
        vecs[2] = '{16'h0000, 24'h808080, 24'h000000};
        vecs[3] = '{16'hE007, 24'h807F80, 24'h00FF00};
        vecs[4] = '{16'h1F00, 24'h80807F, 24'h0000FF};
        vecs[5] = '{16'h0080, 24'h048080, 24'h840000};
        vecs[6] = '{16'h2000, 24'h808480, 24'h000400};
        vecs[7] = '{16'h0008, 24'h888080, 24'h080000};

        rst = 1'b1; start = 1'b0; abort = 1'b0; data_valid = 1'b0; data_in = '0;
        repeat (3) tick();
        chk_all_zero("reset");

        // Back-to-back table frame straight out of reset.
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start rd_ready", 32'(rd_ready_s), 1);
        chk("start busy",     32'(busy_s), 1);
        for (int i = 0; i < 8; i++) begin
            data_in    = vecs[i].din;
            data_valid = 1'b1;
            tick();
            chk("tbl mem_we",     32'(mem_we_s), 1);
            chk("tbl mem_addr",   32'(mem_addr_s), 32'(i));
            chk("tbl wdata_s",    32'(mem_wdata_s), 32'(vecs[i].exp_s));
            chk("tbl wdata_u",    32'(mem_wdata_u), 32'(vecs[i].exp_u));
            chk("tbl frame_done", 32'(frame_done_s), 32'(i == 7));
            chk("tbl rd_ready",   32'(rd_ready_s), 32'(i != 7));
        end
        data_valid = 1'b0;

        // Re-arm: start one cycle after frame_done; rd_ready low time must be exactly MIN_LOW.
        low_cycles = 1;
        tick();
        n = 0;
        while (!rd_ready_s && n < 40) begin
            low_cycles++;
            start = (n == 0);
            tick();
            start = 1'b0;
            n++;
        end
        chk("rearm rd_ready rises", 32'(rd_ready_s), 1);
        chk("rearm low cycles",     32'(low_cycles), ML);

        // Abort after 5 pixels.
        for (int i = 0; i < 5; i++) put_word(i, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort rd_ready", 32'(rd_ready_s), 0);
        chk("abort busy",     32'(busy_s), 0);
        chk("abort mem_we",   32'(mem_we_s), 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            seen += int'(frame_done_s) + int'(mem_we_s);
            tick();
        end
        chk("abort no done/we", 32'(seen), 0);

        // Abort and start together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort+start busy", 32'(busy_s), 0);
        tick();
        chk("abort+start rd_ready", 32'(rd_ready_s), 0);

        // Next frame restarts at 0; every third cycle valid.
        open_frame();
        feed_frame(2, 1'b0);

        for (int f = 0; f < 5; f++) begin
            open_frame();
            feed_frame(int'($urandom_range(0, 3)), f == 1);
        end

        // Words in IDLE are dropped and flagged; start clears the flag.
        for (int k = 0; k < 3; k++) begin
            data_in    = 16'($urandom);
            data_valid = 1'b1;
            tick();
            data_valid = 1'b0;
            chk("idle drop mem_we", 32'(mem_we_s), 0);
            tick();
            chk("idle drop mem_we gap", 32'(mem_we_s), 0);
        end
        chk("idle drop_err set", 32'(drop_err_s), 1);
        open_frame();
        chk("drop_err cleared by start", 32'(drop_err_s), 0);

        // Start while busy is ignored; then reset mid-frame after pixel 3.
        put_word(0, 1'b0);
        put_word(1, 1'b0);
        start = 1'b1;
        put_word(2, 1'b0);
        start = 1'b0;
        put_word(3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("mid-frame reset");
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            data_in    = 16'($urandom);
            data_valid = 1'b1;
            tick();
            seen += int'(mem_we_s) + int'(rd_ready_s);
        end
        data_valid = 1'b0;
        chk("post reset no writes", 32'(seen), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
